div_seq: RTL

Sequencer for the multi-cycle radix-2 unsigned divider in the CPU's HI/LO unit. It accepts DIV/DIVU requests from the execute stage and stalls the pipeline while the divider runs. Signed operands are converted to magnitudes before the divider is started, and the divider's quotient/remainder are sign-corrected before a one-cycle HI/LO write pulse. Divide-by-zero is handled without the divider, and an in-flight operation can be flushed.

---
 rtl/div_pkg.sv | 15 +
 rtl/div_sign_fix.sv | 12 +
 rtl/div_seq.sv | 127 ++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the divide sequencer
package div_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        DONE,
        DRAIN
    } state_t;

    localparam int          DIV_ITERS = 32;
    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_sign_fix.sv
// rtl/div_sign_fix.sv - conditional two's-complement negate
module div_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    assign y = neg ? (~a + 1'b1) : a;

endmodule

// File: rtl/div_seq.sv
// rtl/div_seq.sv - DIV/DIVU sequencer around a 32-iteration unsigned divider
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_start,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic             div_over,
    input  logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_r
);

    state_t           state;
    state_t           state_next;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] mag_rs;
    logic [WIDTH-1:0] mag_rt;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH-1:0] dividend_reg;
    logic [WIDTH-1:0] divisor_reg;
    logic             accept;

    div_sign_fix #(.WIDTH(WIDTH)) u_abs_rs (
        .neg (is_signed & rs[WIDTH-1]),
        .a   (rs),
        .y   (mag_rs)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_abs_rt (
        .neg (is_signed & rt[WIDTH-1]),
        .a   (rt),
        .y   (mag_rt)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_fix_q (
        .neg (neg_q),
        .a   (div_q),
        .y   (q_fix)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_fix_r (
        .neg (neg_r),
        .a   (div_r),
        .y   (r_fix)
    );

    // A flush in IDLE suppresses the request for that cycle.
    assign accept = (state == IDLE) && req && !flush;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (rt == '0) ? DONE : START;
                end
            end
            START: state_next = flush ? DRAIN : WAIT;
            WAIT: begin
                // A flush coinciding with div_over has nothing left to drain.
                if (flush) begin
                    state_next = div_over ? IDLE : DRAIN;
                end else if (div_over) begin
                    state_next = DONE;
                end
            end
            DONE:  state_next = IDLE;
            DRAIN: begin
                if (div_over) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            hi           <= '0;
            lo           <= '0;
            dividend_reg <= '0;
            divisor_reg  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                if (rt == '0) begin
                    hi <= rs;
                    lo <= DIV0_QUOT[WIDTH-1:0];
                end else begin
                    dividend_reg <= mag_rs;
                    divisor_reg  <= mag_rt;
                    neg_q        <= is_signed & (rs[WIDTH-1] ^ rt[WIDTH-1]);
                    neg_r        <= is_signed & rs[WIDTH-1];
                end
            end
            if ((state == WAIT) && div_over && !flush) begin
                lo <= q_fix;
                hi <= r_fix;
            end
        end
    end

    assign busy         = (state != IDLE);
    assign done         = (state == DONE) && !flush;
    assign div_start    = (state == START);
    assign div_dividend = dividend_reg;
    assign div_divisor  = divisor_reg;

endmodule
